// File: rtl/stream_cipher_pkg.sv
// Shared definitions for the 8-bit LFSR stream cipher. The encryptor and decryptor both use
// this package, so their keystreams are generated by the same code.
package stream_cipher_pkg;

  localparam int N = 8;
  localparam logic [N-1:0] SEED = 8'hCD;
  localparam logic [N-1:0] TAP  = 8'hB8;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

  // Fibonacci step: the feedback bit is the parity of the tapped bits 7,5,4,3.
  function automatic logic [N-1:0] lfsr_next(input logic [N-1:0] key);
    return {key[N-2:0], ^(key & TAP)};
  endfunction

endpackage

// File: rtl/sc_fifo.sv
// Small first-word-fall-through FIFO. The head entry is driven from storage registers,
// and full/empty come from a registered occupancy count.
module sc_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/stream_decipher_rx.sv
// Receive-side stream decipher: XORs each ciphertext byte with the regenerated LFSR keystream
// and queues plaintext in a small output FIFO. The keystream reseeds at every frame end.
module stream_decipher_rx #(
  parameter int             N        = stream_cipher_pkg::N,
  parameter logic [N-1:0]   SEED     = stream_cipher_pkg::SEED,
  parameter int             FIFO_DEP = 2,
  parameter int             CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      dec_en,
  input  logic                      seed_load,
  input  logic [N-1:0]              seed,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [N-1:0]              s_data,
  input  logic                      s_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [N-1:0]              m_data,
  output logic                      m_last,
  output logic [CNT_W-1:0]          byte_cnt,
  output logic                      seed_err,
  output stream_cipher_pkg::state_e state_dbg
);

  import stream_cipher_pkg::*;

  localparam int W = N + 1;

  state_e         state;
  state_e         state_nxt;
  logic [N-1:0]   key;
  logic           accept;
  logic           pop;
  logic           flush_done;
  logic           load_ok;
  logic           fifo_full;
  logic           fifo_empty;
  logic [W-1:0]   fifo_din;
  logic [W-1:0]   fifo_dout;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // s_ready depends only on registered state, never on s_valid or m_ready.
  assign s_ready    = (state == RUN) && !fifo_full;
  assign accept     = s_valid && s_ready;
  assign m_valid    = !fifo_empty;
  assign pop        = m_valid && m_ready;
  assign flush_done = (state == FLUSH) && fifo_empty;
  assign load_ok    = seed_load && (state != FLUSH);
  assign fifo_din   = {s_last, dec_en ? (s_data ^ key) : s_data};
  assign m_last     = fifo_dout[W-1];
  assign m_data     = fifo_dout[N-1:0];
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = RUN;
      RUN:     if (accept && s_last) state_nxt = FLUSH;
      FLUSH:   if (fifo_empty) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame-end reseed beats a seed load, and a seed load beats the keystream advance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key      <= SEED;
      seed_err <= 1'b0;
    end else if (flush_done) begin
      key <= SEED;
    end else if (load_ok) begin
      if (seed == '0) seed_err <= 1'b1;
      else            key      <= seed;
    end else if (accept && dec_en) begin
      key <= lfsr_next(key);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        byte_cnt <= '0;
    else if (flush_done) byte_cnt <= '0;
    else if (accept)     byte_cnt <= byte_cnt + CNT_W'(1);
  end

  sc_fifo #(
    .DEPTH (FIFO_DEP),
    .W     (W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (accept),
    .din     (fifo_din),
    .pop     (pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_stream_decipher_rx.sv
// Bench for stream_decipher_rx: directed vector table, hand-written corner sequences,
// and randomized traffic checked every cycle against a queue-based reference model.
module tb_stream_decipher_rx;

  localparam int         FIFO_DEP = 2;
  localparam int         W        = 9;
  localparam logic [7:0] SEED     = 8'hCD;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        dec_en = 1'b1;
  logic        seed_load = 1'b0;
  logic [7:0]  seed = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = 8'h00;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [7:0]  m_data;
  logic        m_last;
  logic [15:0] byte_cnt;
  logic        seed_err;
  stream_cipher_pkg::state_e state_dbg;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  stream_decipher_rx dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .dec_en    (dec_en),
    .seed_load (seed_load),
    .seed      (seed),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .byte_cnt  (byte_cnt),
    .seed_err  (seed_err),
    .state_dbg (state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Keystream step: shift left, new LSB = parity of bits 7,5,4,3.
  function automatic logic [7:0] key_step(input logic [7:0] k);
    return (k << 1) | 8'($countones(k & 8'hB8) % 2);
  endfunction

  logic [W-1:0] exp_q[$];
  logic [7:0]   mdl_key;
  int unsigned  mdl_cnt;
  bit           mdl_run;
  bit           mdl_flush;
  bit           mdl_err;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
      mdl_key   = SEED;
      mdl_cnt   = 0;
      mdl_run   = 1'b0;
      mdl_flush = 1'b0;
      mdl_err   = 1'b0;
    end else begin
      bit acc;
      bit frame_done;
      acc        = s_valid && mdl_run && !mdl_flush && (exp_q.size() < FIFO_DEP);
      frame_done = mdl_flush && (exp_q.size() == 0);
      if (exp_q.size() > 0 && m_ready) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back({s_last, dec_en ? (s_data ^ mdl_key) : s_data});
        mdl_cnt = (mdl_cnt + 1) % 65536;
      end
      if (frame_done) begin
        mdl_key = SEED;
        mdl_cnt = 0;
      end else if (seed_load && !mdl_flush) begin
        if (seed == 8'h00) mdl_err = 1'b1;
        else               mdl_key = seed;
      end else if (acc && dec_en) begin
        mdl_key = key_step(mdl_key);
      end
      if (frame_done) mdl_flush = 1'b0;
      if (acc && s_last) mdl_flush = 1'b1;
      mdl_run = 1'b1;
    end
  end

  // ---------------- scoreboard (sampled on the falling edge) ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("sb_s_ready", s_ready, mdl_run && !mdl_flush && (exp_q.size() < FIFO_DEP));
      check("sb_m_valid", m_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) check("sb_head", {m_last, m_data}, exp_q[0]);
      check("sb_byte_cnt", byte_cnt, mdl_cnt);
      check("sb_seed_err", seed_err, mdl_err);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!s_ready && n < 40) begin
      tick();
      n++;
    end
    check(name, s_ready, 1);
  endtask

  typedef struct {
    logic [7:0]  din;
    logic        last;
    logic [7:0]  exp_data;
    logic        exp_last;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[6];

  // ---------------- stimulus ----------------
  initial begin
    // keystream from zeros, then a loopback frame encrypted with the same keystream
    vecs[0] = '{8'h00,          1'b0, 8'hCD, 1'b0, 16'd1};
    vecs[1] = '{8'h00,          1'b0, 8'h9A, 1'b0, 16'd2};
    vecs[2] = '{8'h00,          1'b1, 8'h35, 1'b1, 16'd3};
    vecs[3] = '{8'h11 ^ 8'hCD,  1'b0, 8'h11, 1'b0, 16'd1};
    vecs[4] = '{8'h22 ^ 8'h9A,  1'b0, 8'h22, 1'b0, 16'd2};
    vecs[5] = '{8'h33 ^ 8'h35,  1'b1, 8'h33, 1'b1, 16'd3};

    #12;
    check("rst_s_ready",  s_ready,  0);
    check("rst_m_valid",  m_valid,  0);
    check("rst_m_data",   m_data,   0);
    check("rst_m_last",   m_last,   0);
    check("rst_byte_cnt", byte_cnt, 0);
    check("rst_seed_err", seed_err, 0);
    check("rst_state",    state_dbg, stream_cipher_pkg::IDLE);

    @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    tick();
    check("state_run", state_dbg, stream_cipher_pkg::RUN);

    // table-driven frames
    for (int i = 0; i < 6; i++) begin
      wait_ready($sformatf("vec%0d_ready", i));
      if (i == 3) check("cnt_after_flush", byte_cnt, 0);
      s_valid = 1'b1;
      s_data  = vecs[i].din;
      s_last  = vecs[i].last;
      tick();
      s_valid = 1'b0;
      s_last  = 1'b0;
      check($sformatf("vec%0d_valid", i), m_valid, 1);
      check($sformatf("vec%0d_data", i), m_data, vecs[i].exp_data);
      check($sformatf("vec%0d_last", i), m_last, vecs[i].exp_last);
      check($sformatf("vec%0d_cnt", i), byte_cnt, vecs[i].exp_cnt);
    end
    wait_ready("vec_end_ready");

    // backpressure: two bytes fill the FIFO, third waits; head holds steady
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h10;
    check("bp_ready0", s_ready, 1);
    tick();
    s_data = 8'h20;
    check("bp_ready1", s_ready, 1);
    tick();
    s_data = 8'h30;
    s_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("bp_full", s_ready, 0);
      check("bp_hold", m_data, 8'h10 ^ 8'hCD);
      tick();
    end
    m_ready = 1'b1;
    tick();
    check("bp_second", m_data, 8'h20 ^ 8'h9A);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("bp_third", m_data, 8'h30 ^ 8'h35);
    check("bp_third_last", m_last, 1);
    check("bp_cnt", byte_cnt, 3);
    check("flush_not_ready", s_ready, 0);
    wait_ready("bp_end_ready");
    check("bp_cnt_cleared", byte_cnt, 0);

    // seed load alongside an accept, then a rejected all-zero seed
    s_valid   = 1'b1;
    s_data    = 8'h00;
    seed_load = 1'b1;
    seed      = 8'h01;
    tick();
    seed_load = 1'b0;
    check("sl_old_key", m_data, 8'hCD);
    tick();
    check("sl_new_key", m_data, 8'h01);
    s_valid   = 1'b0;
    seed_load = 1'b1;
    seed      = 8'h00;
    tick();
    seed_load = 1'b0;
    check("sl_zero_err", seed_err, 1);
    s_valid = 1'b1;
    s_last  = 1'b1;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("sl_key_kept", m_data, 8'h02);
    wait_ready("sl_end_ready");

    // bypass leaves the keystream untouched
    dec_en  = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hA5;
    tick();
    check("byp_data", m_data, 8'hA5);
    check("byp_cnt", byte_cnt, 1);
    dec_en = 1'b1;
    s_data = 8'h00;
    s_last = 1'b1;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("byp_key_held", m_data, 8'hCD);
    check("byp_cnt2", byte_cnt, 2);
    wait_ready("byp_end_ready");

    // asynchronous reset in the middle of a frame
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h5A;
    tick();
    s_valid = 1'b0;
    check("mid_valid_before", m_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_cnt", byte_cnt, 0);
    check("mid_rst_ready", s_ready, 0);
    check("mid_rst_err", seed_err, 0);
    #3;
    reset_n = 1'b1;
    tick();

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      s_valid   = ($urandom_range(0, 3) != 0);
      s_data    = 8'($urandom_range(0, 255));
      s_last    = ($urandom_range(0, 7) == 0);
      dec_en    = ($urandom_range(0, 5) != 0);
      m_ready   = ($urandom_range(0, 3) != 0);
      seed_load = ($urandom_range(0, 40) == 0);
      seed      = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      tick();
    end
    s_valid   = 1'b0;
    s_last    = 1'b0;
    seed_load = 1'b0;
    m_ready   = 1'b1;
    repeat (10) tick();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
